hazard_stall_ctrl: RTL and testbench

- Hazard controller for the 5-stage MIPS pipeline. It generates the stall and flush controls consumed by the F/D and D/E pipeline registers.
- It keeps its own Tnew scoreboard of the instructions in the E, M and W stages. It compares that scoreboard against the Tuse demands of the instruction currently in D.
- It tracks the multi-cycle mult/div unit through a busy counter, so HI/LO users in D are held until the result is ready.

---
 rtl/hazard_stall_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush controller with Tnew scoreboard and mult/div busy tracking
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_rs_used,
    input  logic       D_rt_used,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_tnew,
    input  logic [1:0] D_md_start,
    input  logic       D_md_use,
    output logic       F_stall,
    output logic       D_stall,
    output logic       DE_flush,
    output logic       md_busy
);

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // Scoreboard slots: destination register and remaining cycles until forwardable
    logic [4:0] e_dst_q, e_dst_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_dst_q, m_dst_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_dst_q, w_dst_d;
    logic [1:0] w_tnew_q, w_tnew_d;

    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic stall;

    // The W slot has no consumer in the stall equations; it only mirrors
    // the pipeline for debug visibility.
    logic [6:0] w_slot_unused;
    assign w_slot_unused = {w_dst_q, w_tnew_q};

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        sat_dec = (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // Data and HI/LO hazard detection against the E and M slots
    always_comb begin
        hz_rs = D_rs_used && (D_rs != 5'd0) &&
                (((e_dst_q == D_rs) && (e_tnew_q > D_tuse_rs)) ||
                 ((m_dst_q == D_rs) && (m_tnew_q > D_tuse_rs)));
        hz_rt = D_rt_used && (D_rt != 5'd0) &&
                (((e_dst_q == D_rt) && (e_tnew_q > D_tuse_rt)) ||
                 ((m_dst_q == D_rt) && (m_tnew_q > D_tuse_rt)));
        hz_md = D_md_use && (busy_cnt_q != '0);
        stall = hz_rs || hz_rt || hz_md;
    end

    assign F_stall  = stall;
    assign D_stall  = stall;
    assign DE_flush = stall;
    assign md_busy  = (busy_cnt_q != '0);

    // Scoreboard advance: a stalled D enters E as a bubble
    always_comb begin
        e_dst_d  = stall ? 5'd0 : D_dst;
        e_tnew_d = stall ? 2'd0 : D_tnew;
        m_dst_d  = e_dst_q;
        m_tnew_d = sat_dec(e_tnew_q);
        w_dst_d  = m_dst_q;
        w_tnew_d = sat_dec(m_tnew_q);
    end

    // Busy counter: load only when the mult/div actually moves into E
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (!stall && (D_md_start == MD_MULT)) begin
            busy_cnt_d = CNT_W'(MULT_CYCLES);
        end else if (!stall && (D_md_start == MD_DIV)) begin
            busy_cnt_d = CNT_W'(DIV_CYCLES);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously so a reset aborts any stall at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q    <= 5'd0;
            e_tnew_q   <= 2'd0;
            m_dst_q    <= 5'd0;
            m_tnew_q   <= 2'd0;
            w_dst_q    <= 5'd0;
            w_tnew_q   <= 2'd0;
            busy_cnt_q <= '0;
        end else begin
            e_dst_q    <= e_dst_d;
            e_tnew_q   <= e_tnew_d;
            m_dst_q    <= m_dst_d;
            m_tnew_q   <= m_tnew_d;
            w_dst_q    <= w_dst_d;
            w_tnew_q   <= w_tnew_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    logic md_none_unused;
    assign md_none_unused = (D_md_start == MD_NONE);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic       D_rs_used;
    logic       D_rt_used;
    logic [1:0] D_tuse_rs;
    logic [1:0] D_tuse_rt;
    logic [4:0] D_dst;
    logic [1:0] D_tnew;
    logic [1:0] D_md_start;
    logic       D_md_use;
    logic       F_stall;
    logic       D_stall;
    logic       DE_flush;
    logic       md_busy;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rs_used (D_rs_used),
        .D_rt_used (D_rt_used),
        .D_tuse_rs (D_tuse_rs),
        .D_tuse_rt (D_tuse_rt),
        .D_dst     (D_dst),
        .D_tnew    (D_tnew),
        .D_md_start(D_md_start),
        .D_md_use  (D_md_use),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .DE_flush  (DE_flush),
        .md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // All three stall-family outputs must agree with the expected stall
    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".F_stall"},  F_stall,  exp);
        chk({tag, ".D_stall"},  D_stall,  exp);
        chk({tag, ".DE_flush"}, DE_flush, exp);
    endtask

    task automatic idle();
        D_rs = 5'd0; D_rt = 5'd0; D_rs_used = 1'b0; D_rt_used = 1'b0;
        D_tuse_rs = 2'd0; D_tuse_rt = 2'd0; D_dst = 5'd0; D_tnew = 2'd0;
        D_md_start = 2'b00; D_md_use = 1'b0;
    endtask

    // Advance one edge; inputs are then changed at posedge+2, checks at posedge+3
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic flush_pipe();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset held with hazard-looking inputs
        D_rs = 5'd8; D_rs_used = 1'b1; D_md_use = 1'b1; D_dst = 5'd8;
        D_tnew = 2'd2; D_md_start = 2'b10;
        repeat (2) tick();
        #1;
        chk_stall("reset", 1'b0);
        chk("reset.md_busy", md_busy, 1'b0);
        reset = 1'b1;
        idle();
        #1;
        chk_stall("post_reset", 1'b0);
        chk("post_reset.md_busy", md_busy, 1'b0);

        // Load-use: tuse=1 against a load in E stalls one cycle
        flush_pipe();
        D_dst = 5'd8; D_tnew = 2'd2;
        #1 chk_stall("lu.producer", 1'b0);
        tick();
        idle();
        D_rs = 5'd8; D_rs_used = 1'b1; D_tuse_rs = 2'd1; D_dst = 5'd10; D_tnew = 2'd1;
        #1 chk_stall("lu.c1", 1'b1);
        tick();
        #1 chk_stall("lu.c2", 1'b0);

        // Load-branch: tuse=0 stalls two cycles
        flush_pipe();
        D_dst = 5'd8; D_tnew = 2'd2;
        tick();
        idle();
        D_rs = 5'd8; D_rs_used = 1'b1; D_tuse_rs = 2'd0;
        #1 chk_stall("lb.c1", 1'b1);
        tick();
        #1 chk_stall("lb.c2", 1'b1);
        tick();
        #1 chk_stall("lb.c3", 1'b0);

        // ALU-branch on rt: one-cycle stall
        flush_pipe();
        D_dst = 5'd9; D_tnew = 2'd1;
        tick();
        idle();
        D_rt = 5'd9; D_rt_used = 1'b1; D_tuse_rt = 2'd0;
        #1 chk_stall("ab.c1", 1'b1);
        tick();
        #1 chk_stall("ab.c2", 1'b0);

        // Register 0 never creates a hazard
        flush_pipe();
        D_dst = 5'd0; D_tnew = 2'd1;
        tick();
        idle();
        D_rt = 5'd0; D_rt_used = 1'b1; D_tuse_rt = 2'd0;
        #1 chk_stall("r0", 1'b0);

        // Unused source operand does not stall
        flush_pipe();
        D_dst = 5'd7; D_tnew = 2'd2;
        tick();
        idle();
        D_rs = 5'd7; D_rs_used = 1'b0; D_tuse_rs = 2'd0;
        #1 chk_stall("rs_unused", 1'b0);

        // Both operands hazard: one stall held until both clear
        flush_pipe();
        D_dst = 5'd8; D_tnew = 2'd2;
        tick();
        D_dst = 5'd9; D_tnew = 2'd2;
        tick();
        idle();
        D_rs = 5'd8; D_rs_used = 1'b1; D_tuse_rs = 2'd0;
        D_rt = 5'd9; D_rt_used = 1'b1; D_tuse_rt = 2'd0;
        #1 chk_stall("dual.c1", 1'b1);
        tick();
        #1 chk_stall("dual.c2", 1'b1);
        tick();
        #1 chk_stall("dual.c3", 1'b0);

        // Mult then mfhi: five busy cycles
        flush_pipe();
        D_md_start = 2'b01; D_md_use = 1'b1;
        #1 chk_stall("mult.issue", 1'b0);
        chk("mult.issue.md_busy", md_busy, 1'b0);
        tick();
        idle();
        D_md_use = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_stall($sformatf("mfhi.c%0d", i), 1'b1);
            chk($sformatf("mfhi.busy%0d", i), md_busy, 1'b1);
            tick();
        end
        #1 chk_stall("mfhi.release", 1'b0);
        chk("mfhi.release.md_busy", md_busy, 1'b0);

        // A stalled mult must not reload the counter
        flush_pipe();
        D_md_start = 2'b01; D_md_use = 1'b1;
        tick();
        // second mult waits; counter keeps running down 5..1
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("mult2.stall%0d", i), D_stall, 1'b1);
            tick();
        end
        #1 chk("mult2.go", D_stall, 1'b0);
        idle();

        // Async reset mid-div takes effect between edges
        flush_pipe();
        D_md_start = 2'b10; D_md_use = 1'b1;
        tick();
        idle();
        D_md_use = 1'b1;
        repeat (3) tick();
        #1 chk_stall("div.busy", 1'b1);
        chk("div.busy.md_busy", md_busy, 1'b1);
        reset = 1'b0;
        #1;
        chk_stall("div.reset", 1'b0);
        chk("div.reset.md_busy", md_busy, 1'b0);
        reset = 1'b1;
        #1;
        chk_stall("div.after", 1'b0);
        tick();
        #1 chk("div.after.md_busy", md_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
